sync_fifo_core: RTL and testbench
=================================

// Module: sync_fifo_core
// PURPOSE
//  Single-clock FIFO buffer between a producer and a consumer in the same clock domain.
//  Stores up to DEPTH words; exposes full/empty status; read data is registered.
//  Sits directly behind the fifo_intf interface signals (data_in/wr_en in, data_out/rd_en out).
// PARAMETERS
//  DATA_WIDTH  8   width of data_in/data_out in bits
//  DEPTH       16  number of storage words; must be a power of 2, >= 2
// PORTS
//  clk       in   1           single clock; all state updates on rising edge
//  rst_n     in   1           reset, synchronous, active-high (asserted = 1, sampled on clk rising edge)
//  data_in   in   DATA_WIDTH  write data, captured when a write is accepted
//  wr_en     in   1           write request
//  rd_en     in   1           read request
//  data_out  out  DATA_WIDTH  registered read data
//  full      out  1           1 when DEPTH words stored
//  empty     out  1           1 when 0 words stored
// BEHAVIOUR
//  - Reset (rst_n=1 at posedge): wr_ptr=rd_ptr=0, data_out=0, empty=1, full=0; memory contents not cleared.
//  - Reset mid-operation discards all stored words; the next cycle behaves as after power-up reset.
//  - Pointers: $clog2(DEPTH)+1 bits; MSB is wrap bit; address = low bits; wrap DEPTH-1 -> 0.
//  - empty = (wr_ptr == rd_ptr); full = (addr equal, wrap bits differ); both combinational from pointers.
//  - Write accepted = wr_en & (~full | rd_en): mem[wr_addr] <= data_in, wr_ptr+1.
//  - Read accepted = rd_en & ~empty: data_out <= mem[rd_addr], rd_ptr+1; data valid 1 cycle after rd_en.
//  - Read when empty: ignored, data_out holds, pointers unchanged (no underflow).
//  - Write when full and rd_en=0: ignored, word dropped (no overflow, no corruption).
//  - Simultaneous rd_en & wr_en, not empty: both proceed; occupancy unchanged.
//  - Simultaneous on full: read frees a slot, write accepted same edge; full stays 1.
//  - Simultaneous on empty: write accepted, read ignored (no fall-through); empty deasserts next cycle.
//  - data_out holds its last value whenever no read is accepted.
//  - Flag latency: empty/full reflect the pointer update of the same edge (visible next cycle).
// CONFIGURATION
//  Macro SYNC_FIFO_COUNT_EN:
//  - defined: extra output port count [$clog2(DEPTH):0] = wr_ptr - rd_ptr (0..DEPTH), reset 0,
//    updated with the pointers.
//  - undefined: port absent; the rest of the behaviour is identical.
// STRUCTURE
//  - Package sync_fifo_pkg: default DATA_WIDTH/DEPTH localparams, ptr_t width function
//    ($clog2-based), typedef for the data word.
//  - One sub-module: sync_fifo_mem (DEPTH x DATA_WIDTH, 1 write port, 1 registered read port).
//    Pointers, flags and the optional count stay in sync_fifo_core.
// TESTING (DATA_WIDTH=8, DEPTH=16)
//  - Reset: hold rst_n=1 for 2 cycles -> empty=1, full=0, data_out=8'h00.
//  - Fill/drain: write 0x01..0x10 -> full=1 after 16th write; read 16 -> 0x01..0x10 in order,
//    each 1 cycle after rd_en; empty=1.
//  - Overflow/underflow: 17th write 0xAA when full -> dropped, reads still return 0x01..0x10;
//    rd_en when empty -> data_out holds 0x10.
//  - Simultaneous: rd_en&wr_en with 5 stored -> count stays 5, FIFO order kept;
//    on full -> write accepted, full stays 1.
//  - Wrap-around: 3 cycles of write 12 / read 12 words -> data intact across address wrap.
//  - Mid-op reset: 7 words stored, assert rst_n 1 cycle -> empty=1;
//    next write 0x5A then read returns 0x5A.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo_pkg                                                    |
// | Brief   : Shared defaults, pointer-width helper and data word type for the |
// |           single-clock FIFO.                                               |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sync_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 16;

   // One extra bit above the address distinguishes full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo_mem                                                    |
// | Brief   : DEPTH x DATA_WIDTH storage, one write port, one registered read  |
// |           port. Array contents are not reset; read register is.            |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int ADDR_W     = ptr_width(DEPTH) - 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // A same-edge write to rd_addr lands after the read samples the old word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_core.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo_core                                                   |
// | Brief   : Single-clock FIFO with full/empty flags and registered read data.|
// |           Define SYNC_FIFO_COUNT_EN to expose the occupancy port 'count'.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_core
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    wr_en,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    full,
   output logic                    empty
`ifdef SYNC_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH):0]  count
`endif
);

   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic             wr_accept;
   logic             rd_accept;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                  (wr_ptr_q[PTR_W-1]    != rd_ptr_q[PTR_W-1]);

   // A read on a full FIFO frees the slot the same-edge write fills.
   always_comb begin
      rd_accept = rd_en & ~empty;
      wr_accept = wr_en & (~full | rd_en);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

`ifdef SYNC_FIFO_COUNT_EN
   assign count = wr_ptr_q - rd_ptr_q;
`endif

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_accept & ~rst_n),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (data_in),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (data_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_sync_fifo_core                                                |
// | Brief   : Self-checking bench: queue reference model plus scoreboard.      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_core;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
`ifdef SYNC_FIFO_COUNT_EN
   logic [$clog2(DEPTH):0] count;
`endif

   sync_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
`ifdef SYNC_FIFO_COUNT_EN
      ,
      .count    (count)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] model[$];
   logic [DW-1:0] sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: one cycle of stimulus; the model advances to the state the DUT holds after the next edge.
   task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      bit rd_ok, wr_ok;
      @(posedge clk);
      #2;
      rst_n   = r;
      wr_en   = w;
      rd_en   = rd;
      data_in = d;
      if (r) begin
         model.delete();
      end else begin
         rd_ok = rd && (model.size() > 0);
         wr_ok = w && ((model.size() < DEPTH) || rd);
         if (rd_ok) sb.push_back(model.pop_front());
         if (wr_ok) model.push_back(d);
      end
   endtask

   // Monitor: a read handshake seen before an edge makes data_out valid just after it.
   initial begin
      bit            pend = 0;
      bit            rst_seen = 0;
      logic [DW-1:0] last = '0;
      logic [DW-1:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (rst_seen) last = '0;
         if (pend) begin
            if (sb.size() == 0) begin
               check("scoreboard_underrun", 1, 0);
            end else begin
               exp  = sb.pop_front();
               last = exp;
            end
         end
         check("data_out", int'(data_out), int'(last));
         check("empty", int'(empty), int'(model.size() == 0));
         check("full", int'(full), int'(model.size() == DEPTH));
`ifdef SYNC_FIFO_COUNT_EN
         check("count", int'(count), model.size());
`endif
         #6;
         rst_seen = rst_n;
         pend     = !rst_n && rd_en && !empty;
      end
   end

   initial begin
      int mode;
      // Reset held two cycles
      cycle(1, 0, 0, 8'h00);
      cycle(1, 0, 0, 8'h00);
      // Fill 0x01..0x10, then overflow attempt
      for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, DW'(i));
      cycle(0, 1, 0, 8'hAA);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
      // Underflow: data_out must hold 0x10
      cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 1, 8'h00);
      // Simultaneous on empty: write only
      cycle(0, 1, 1, 8'h77);
      cycle(0, 0, 1, 8'h00);
      // Simultaneous with 5 stored
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, DW'(8'h20 + i));
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, DW'(8'h30 + i));
      // Top up to full, simultaneous on full
      for (int i = 0; i < 11; i++) cycle(0, 1, 0, DW'(8'h40 + i));
      cycle(0, 1, 1, 8'hC1);
      cycle(0, 1, 1, 8'hC2);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);
      // Wrap-around
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) cycle(0, 1, 0, DW'(k * 16 + i + 8'h60));
         for (int i = 0; i < 12; i++) cycle(0, 0, 1, 8'h00);
      end
      // Mid-operation reset
      for (int i = 0; i < 7; i++) cycle(0, 1, 0, DW'(8'h90 + i));
      cycle(1, 0, 0, 8'h00);
      cycle(0, 1, 0, 8'h5A);
      cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 0, 8'h00);
      // Randomised traffic with varying write/read bias and rare resets
      for (int i = 0; i < 3000; i++) begin
         mode = (i / 250) % 3;
         cycle($urandom_range(299) == 0,
               $urandom_range(99) < (mode == 0 ? 75 : (mode == 1 ? 25 : 50)),
               $urandom_range(99) < (mode == 0 ? 25 : (mode == 1 ? 75 : 50)),
               DW'($urandom_range(255)));
      end
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
